// File: rtl/mem_rw_pipe.sv
// Single-port word memory with byte-enabled writes, a fixed-latency read pipeline and a
// first-word fall-through response FIFO; read credits cover in-flight reads so the FIFO never overflows.
module mem_rw_pipe #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic [ADDR_W-1:0]              i_req_addr,
  input  logic                           i_req_rw,
  input  logic [DATA_W-1:0]              i_req_data,
  input  logic [DATA_W/8-1:0]            i_req_be,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [DATA_W-1:0]              o_rsp_data,
  output logic                           o_rsp_err,
  output logic [$clog2(RSP_DEPTH+1)-1:0] o_rd_outstanding
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RSP_DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RSP_DEPTH - 1);

  logic [DATA_W-1:0] mem_q   [DEPTH];
  logic [DATA_W-1:0] pdata_q [RD_LAT];
  logic [RD_LAT-1:0] perr_q;
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] fdata_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] ferr_q;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [PTR_W-1:0] wptr_q, rptr_q;

  logic in_range, req_acc, rd_acc, wr_acc, rsp_pop, fifo_push;

  assign in_range         = {1'b0, i_req_addr} < DEPTH_L;
  assign o_req_ready      = (cnt_q != CNT_FULL);
  assign req_acc          = i_req_valid & o_req_ready;
  assign rd_acc           = req_acc & ~i_req_rw;
  assign wr_acc           = req_acc & i_req_rw & in_range;
  assign o_rsp_valid      = (fcnt_q != '0);
  assign rsp_pop          = o_rsp_valid & i_rsp_ready;
  assign fifo_push        = vld_q[RD_LAT-1];
  assign o_rsp_data       = fdata_q[rptr_q];
  assign o_rsp_err        = o_rsp_valid & ferr_q[rptr_q];
  assign o_rd_outstanding = cnt_q;

  // Datapath: memory, read pipeline and FIFO storage are never reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      for (int k = 0; k < BE_W; k++) begin
        if (i_req_be[k]) mem_q[i_req_addr][8*k +: 8] <= i_req_data[8*k +: 8];
      end
    end
    pdata_q[0] <= in_range ? mem_q[i_req_addr] : '0;
    perr_q[0]  <= ~in_range;
    for (int s = 1; s < RD_LAT; s++) begin
      pdata_q[s] <= pdata_q[s-1];
      perr_q[s]  <= perr_q[s-1];
    end
    if (fifo_push) begin
      fdata_q[wptr_q] <= pdata_q[RD_LAT-1];
      ferr_q[wptr_q]  <= perr_q[RD_LAT-1];
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    fcnt_d = fcnt_q;
    if (rd_acc && !rsp_pop)      cnt_d = cnt_q + 1'b1;
    else if (!rd_acc && rsp_pop) cnt_d = cnt_q - 1'b1;
    if (fifo_push && !rsp_pop)      fcnt_d = fcnt_q + 1'b1;
    else if (!fifo_push && rsp_pop) fcnt_d = fcnt_q - 1'b1;
  end

  // Control: credits, pipeline valids and FIFO pointers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q  <= '0;
      fcnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      vld_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      vld_q[0] <= rd_acc;
      for (int s = 1; s < RD_LAT; s++) vld_q[s] <= vld_q[s-1];
      if (fifo_push) wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      if (rsp_pop)   rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_rw_pipe.sv
// Randomized and directed bench for mem_rw_pipe against a queue-based reference model
// of memory contents, read credits and timed in-order responses.
module tb_mem_rw_pipe;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 200;
  localparam int RD_LAT    = 3;
  localparam int RSP_DEPTH = 4;
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_rw = 1'b0;
  logic [DATA_W-1:0] req_data = '0;
  logic [3:0]        req_be = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [CNT_W-1:0]  rd_outstanding;

  always #5 clk = ~clk;

  mem_rw_pipe #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .i_clk(clk),
    .i_reset_n(reset_n),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_addr(req_addr),
    .i_req_rw(req_rw),
    .i_req_data(req_data),
    .i_req_be(req_be),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data),
    .o_rsp_err(rsp_err),
    .o_rd_outstanding(rd_outstanding)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          avail;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  int          cyc = 0;
  int          ref_cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_data = '0;
  logic        last_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic step(input logic v, input logic rw, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic rr, output logic acc);
    logic exp_vld, pop;
    rsp_t r;
    @(negedge clk);
    req_valid = v; req_rw = rw; req_addr = a; req_data = d; req_be = be; rsp_ready = rr;
    exp_vld = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    check("rsp_valid", rsp_valid, exp_vld);
    if (exp_vld) begin
      check("rsp_data", rsp_data, exp_q[0].data);
      check("rsp_err", rsp_err, exp_q[0].err);
    end
    check("req_ready", req_ready, ref_cnt != RSP_DEPTH);
    check("outstanding", rd_outstanding, ref_cnt);
    acc = v && (ref_cnt != RSP_DEPTH);
    pop = exp_vld && rr;
    @(posedge clk);
    cyc++;
    if (pop) begin
      last_data = exp_q[0].data;
      last_err  = exp_q[0].err;
      void'(exp_q.pop_front());
      ref_cnt--;
    end
    if (acc && rw) begin
      if (a < DEPTH)
        for (int k = 0; k < 4; k++)
          if (be[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
    end else if (acc) begin
      r.data  = (a < DEPTH) ? ref_mem[a] : 32'h0;
      r.err   = (a >= DEPTH);
      r.avail = cyc + RD_LAT;
      exp_q.push_back(r);
      ref_cnt++;
    end
  endtask

  task automatic send(input logic rw, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic rr);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) step(1'b1, rw, a, d, be, rr, acc);
    check("send_accept", acc, 1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) step(1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b1, acc);
    step(1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b1, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    cyc++;
    exp_q.delete();
    ref_cnt = 0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_outstanding", rd_outstanding, 0);
    check("rst_req_ready", req_ready, 1);
    reset_n = 1'b1;
  endtask

  initial begin
    logic       pend, rv, rw, rr, acc;
    logic [7:0] ra;
    logic [31:0] rd;
    logic [3:0] rbe;

    do_reset();
    for (int a = 0; a < DEPTH; a++) send(1'b1, 8'(a), $urandom, 4'hF, 1'b1);

    // Full write then read back.
    send(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    send(1'b0, 8'h10, 32'h0, 4'h0, 1'b1);
    drain();
    check("t1_data", last_data, 32'hDEADBEEF);
    check("t1_err", last_err, 0);

    // Partial byte-enable write.
    send(1'b1, 8'h20, 32'h11223344, 4'hF, 1'b1);
    send(1'b1, 8'h20, 32'hAABBCCDD, 4'h5, 1'b1);
    send(1'b0, 8'h20, 32'h0, 4'h0, 1'b1);
    drain();
    check("t2_data", last_data, 32'h11BB33DD);

    // Credit exhaustion under backpressure.
    for (int i = 0; i < 4; i++) send(1'b0, 8'(i), 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h4, 32'h0, 4'h0, 1'b0, acc);
    #1;
    check("t3_req_ready", req_ready, 0);
    check("t3_outstanding", rd_outstanding, 4);
    send(1'b0, 8'h4, 32'h0, 4'h0, 1'b1);
    send(1'b0, 8'h5, 32'h0, 4'h0, 1'b1);
    drain();
    check("t3_last_data", last_data, ref_mem[5]);

    // Out-of-range read and dropped write.
    send(1'b1, 8'h00, 32'hCAFEF00D, 4'hF, 1'b1);
    send(1'b0, 8'hF0, 32'h0, 4'h0, 1'b1);
    drain();
    check("t4_err", last_err, 1);
    check("t4_data", last_data, 32'h0);
    send(1'b1, 8'hF0, 32'h12345678, 4'hF, 1'b1);
    send(1'b0, 8'h00, 32'h0, 4'h0, 1'b1);
    drain();
    check("t4_mem0", last_data, 32'hCAFEF00D);

    // Streaming reads.
    for (int i = 0; i < 8; i++) send(1'b0, 8'(i), 32'h0, 4'h0, 1'b1);
    drain();

    // Reset with reads in flight.
    for (int i = 1; i < 4; i++) send(1'b0, 8'(i), 32'h0, 4'h0, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b1, acc);
    send(1'b0, 8'h10, 32'h0, 4'h0, 1'b1);
    drain();
    check("t6_retained", last_data, 32'hDEADBEEF);

    // Random traffic with held requests and varying backpressure.
    pend = 1'b0; rv = 1'b0; rw = 1'b0; ra = '0; rd = '0; rbe = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!pend) begin
        rv  = ($urandom_range(0, 3) != 0);
        rw  = ($urandom_range(0, 2) == 0);
        ra  = 8'($urandom_range(0, 255));
        rd  = $urandom;
        rbe = 4'($urandom_range(0, 15));
      end
      rr = ((c / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(rv, rw, ra, rd, rbe, rr, acc);
      pend = rv && !acc;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
